// File: rtl/dma_axi_mem_slave_if.sv
// AXI4 channel bundle between the DMA master port and the memory slave.
interface dma_axi_mem_slave_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);
  localparam int SB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [31:0]           awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [SB-1:0]         wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dma_axi_mem_slave.sv
// AXI4 scratchpad slave: one outstanding burst per direction, SLVERR counter.
module dma_axi_mem_slave #(
  parameter int          DATA_WIDTH = 512,
  parameter int          MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          ID_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  dma_axi_mem_slave_if.slave axi_io,
  output logic [15:0]        slv_err_cnt_o
);
  localparam int SB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(SB);
  localparam int IW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wstate_e               w_q, w_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [31:0]           waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d;

  rstate_e               r_q, r_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [31:0]           raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rberr_q, rberr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [15:0]           err_q, err_d;

  logic                  wbeat_oor, wend, mem_we;
  logic                  rf_en, rf_bad;
  logic [31:0]           rf_addr;
  logic                  b_err, r_err;
  logic [16:0]           err_sum;

  function automatic logic oor(input logic [31:0] a);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return d[32] || ((d[31:0] >> OFS) >= 32'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] widx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> OFS);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a,
                                       input logic [2:0] sz,
                                       input logic [1:0] bt);
    return (bt == 2'b01) ? a + (32'd1 << sz) : a;
  endfunction

  function automatic logic bad_burst(input logic [2:0] sz,
                                     input logic [1:0] bt);
    return ({29'd0, sz} > 32'(OFS)) || (bt == 2'b10);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q <= W_IDLE;    wid_q <= '0;    waddr_q <= '0;
      wlen_q <= '0;     wcnt_q <= '0;   wsize_q <= '0;
      wburst_q <= '0;   werr_q <= 1'b0;
      r_q <= R_IDLE;    rid_q <= '0;    raddr_q <= '0;
      rlen_q <= '0;     rcnt_q <= '0;   rsize_q <= '0;
      rburst_q <= '0;   rberr_q <= 1'b0;
      rdata_q <= '0;    rresp_q <= '0;  err_q <= '0;
    end else begin
      w_q <= w_d;       wid_q <= wid_d; waddr_q <= waddr_d;
      wlen_q <= wlen_d; wcnt_q <= wcnt_d; wsize_q <= wsize_d;
      wburst_q <= wburst_d; werr_q <= werr_d;
      r_q <= r_d;       rid_q <= rid_d; raddr_q <= raddr_d;
      rlen_q <= rlen_d; rcnt_q <= rcnt_d; rsize_q <= rsize_d;
      rburst_q <= rburst_d; rberr_q <= rberr_d;
      rdata_q <= rdata_d; rresp_q <= rresp_d; err_q <= err_d;
    end
  end

  // Memory is never reset; a reset cycle blocks any pending beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < SB; b++) begin
        if (axi_io.wstrb[b]) begin
          mem_q[widx(waddr_q)][8*b +: 8] <= axi_io.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_d = w_q;       wid_d = wid_q;     waddr_d = waddr_q;
    wlen_d = wlen_q; wcnt_d = wcnt_q;   wsize_d = wsize_q;
    wburst_d = wburst_q; werr_d = werr_q;
    wbeat_oor = oor(waddr_q);
    wend = axi_io.wlast || (wcnt_q == wlen_q);
    unique case (w_q)
      W_IDLE: if (axi_io.awvalid) begin
        w_d = W_DATA;
        wid_d = axi_io.awid;
        waddr_d = axi_io.awaddr;
        wlen_d = axi_io.awlen;
        wsize_d = axi_io.awsize;
        wburst_d = axi_io.awburst;
        wcnt_d = '0;
        werr_d = bad_burst(axi_io.awsize, axi_io.awburst);
      end
      W_DATA: if (axi_io.wvalid) begin
        wcnt_d = wcnt_q + 8'd1;
        waddr_d = step(waddr_q, wsize_q, wburst_q);
        if (wbeat_oor || (axi_io.wlast != (wcnt_q == wlen_q)))
          werr_d = 1'b1;
        if (wend) w_d = W_RESP;
      end
      W_RESP: if (axi_io.bready) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
    mem_we = rst && (w_q == W_DATA) && axi_io.wvalid
             && !werr_q && !wbeat_oor;
  end

  always_comb begin
    r_d = r_q;       rid_d = rid_q;     raddr_d = raddr_q;
    rlen_d = rlen_q; rcnt_d = rcnt_q;   rsize_d = rsize_q;
    rburst_d = rburst_q; rberr_d = rberr_q;
    rdata_d = rdata_q; rresp_d = rresp_q;
    rf_en = 1'b0;
    rf_addr = raddr_q;
    unique case (r_q)
      R_IDLE: if (axi_io.arvalid) begin
        r_d = R_DATA;
        rid_d = axi_io.arid;
        raddr_d = axi_io.araddr;
        rlen_d = axi_io.arlen;
        rsize_d = axi_io.arsize;
        rburst_d = axi_io.arburst;
        rcnt_d = '0;
        rberr_d = bad_burst(axi_io.arsize, axi_io.arburst);
        rf_en = 1'b1;
        rf_addr = axi_io.araddr;
      end
      R_DATA: if (axi_io.rready) begin
        if (rcnt_q == rlen_q) begin
          r_d = R_IDLE;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
          raddr_d = step(raddr_q, rsize_q, rburst_q);
          rf_en = 1'b1;
          rf_addr = raddr_d;
        end
      end
      default: r_d = R_IDLE;
    endcase
    // Combinational array read sees pre-write contents on a collision.
    rf_bad = rberr_d || oor(rf_addr);
    if (rf_en) begin
      rresp_d = rf_bad ? 2'b10 : 2'b00;
      rdata_d = rf_bad ? '0 : mem_q[widx(rf_addr)];
    end
  end

  always_comb begin
    b_err = (w_q == W_RESP) && axi_io.bready && werr_q;
    r_err = (r_q == R_DATA) && axi_io.rready && (rresp_q == 2'b10);
    err_sum = {1'b0, err_q} + {16'd0, b_err} + {16'd0, r_err};
    err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_comb begin
    axi_io.awready = rst && (w_q == W_IDLE);
    axi_io.wready  = (w_q == W_DATA);
    axi_io.bvalid  = (w_q == W_RESP);
    axi_io.bid     = wid_q;
    axi_io.bresp   = ((w_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;
    axi_io.arready = rst && (r_q == R_IDLE);
    axi_io.rvalid  = (r_q == R_DATA);
    axi_io.rid     = rid_q;
    axi_io.rdata   = rdata_q;
    axi_io.rresp   = rresp_q;
    axi_io.rlast   = (r_q == R_DATA) && (rcnt_q == rlen_q);
    slv_err_cnt_o  = err_q;
  end
endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed and randomized bench for dma_axi_mem_slave against a word-array model.
module tb_dma_axi_mem_slave;
  localparam int DW = 512;
  localparam int DEPTH = 1024;
  localparam int IDW = 4;
  localparam int SB = DW / 8;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] err_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf [16];
  logic [SB-1:0] sbuf [16];

  dma_axi_mem_slave_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW)) axi ();

  dma_axi_mem_slave #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst), .axi_io(axi), .slv_err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic beat_oor(input logic [31:0] ba);
    longint d;
    d = longint'(ba) - longint'(BASE);
    return (d < 0) || (d / SB >= DEPTH);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                            input logic [2:0] sz,
                                            input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + 32'(k) * (32'd1 << sz);
  endfunction

  function automatic int word_of(input logic [31:0] ba);
    return int'((ba - BASE) / 32'(SB));
  endfunction

  task automatic wr_burst(input logic [IDW-1:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input int lastb);
    int t;
    logic bad;
    logic [31:0] ba;
    axi.awid = id; axi.awaddr = a; axi.awlen = len;
    axi.awsize = sz; axi.awburst = bt; axi.awvalid = 1'b1;
    #1;
    t = 0;
    while (!axi.awready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    chk("aw_wait", 1'(t < 50), 1'b1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    bad = (sz > 3'd6) || (bt == 2'b10);
    for (int k = 0; k <= lastb; k++) begin
      axi.wvalid = 1'b1; axi.wdata = wbuf[k];
      axi.wstrb = sbuf[k]; axi.wlast = (k == lastb);
      #1;
      chk("wready", axi.wready, 1'b1);
      chk("awready_busy", axi.awready, 1'b0);
      ba = beat_addr(a, k, sz, bt);
      if (beat_oor(ba)) bad = 1'b1;
      if (!bad)
        for (int b = 0; b < SB; b++)
          if (sbuf[k][b]) ref_mem[word_of(ba)][8*b +: 8] = wbuf[k][8*b +: 8];
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    if (lastb != int'(len)) bad = 1'b1;
    #1;
    chk("bvalid", axi.bvalid, 1'b1);
    chk("bid", axi.bid, id);
    chk("bresp", axi.bresp, bad ? 2'b10 : 2'b00);
    if (bad) exp_err++;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    #1;
    chk("bvalid_clr", axi.bvalid, 1'b0);
    chk("awready_back", axi.awready, 1'b1);
  endtask

  task automatic rd_burst(input logic [IDW-1:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input int stall_pct);
    logic [DW-1:0] ed [$];
    logic [1:0] er [$];
    logic bad, e;
    logic [31:0] ba;
    int t, k;
    bad = (sz > 3'd6) || (bt == 2'b10);
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, i, sz, bt);
      e = bad || beat_oor(ba);
      ed.push_back(e ? '0 : ref_mem[word_of(ba)]);
      er.push_back(e ? 2'b10 : 2'b00);
    end
    axi.arid = id; axi.araddr = a; axi.arlen = len;
    axi.arsize = sz; axi.arburst = bt; axi.arvalid = 1'b1;
    #1;
    t = 0;
    while (!axi.arready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    chk("ar_wait", 1'(t < 50), 1'b1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    k = 0;
    t = 0;
    while (k <= int'(len) && t < 2000) begin
      axi.rready = ($urandom_range(99) >= stall_pct);
      #1;
      chk("rvalid", axi.rvalid, 1'b1);
      chk("rid", axi.rid, id);
      chk("rdata", axi.rdata, ed[k]);
      chk("rresp", axi.rresp, er[k]);
      chk("rlast", axi.rlast, 1'(k == int'(len)));
      chk("arready_busy", axi.arready, 1'b0);
      if (axi.rready) begin
        if (er[k] == 2'b10) exp_err++;
        k++;
      end
      t++;
      @(negedge clk);
    end
    axi.rready = 1'b0;
    chk("r_wait", 1'(t < 2000), 1'b1);
    #1;
    chk("rvalid_clr", axi.rvalid, 1'b0);
    chk("arready_back", axi.arready, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0] l;
    logic [1:0] bt;
    logic [DW-1:0] tmp;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
    axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", axi.awready, 1'b0);
    chk("rst_arready", axi.arready, 1'b0);
    chk("rst_wready", axi.wready, 1'b0);
    chk("rst_bvalid", axi.bvalid, 1'b0);
    chk("rst_rvalid", axi.rvalid, 1'b0);
    chk("rst_rdata", axi.rdata, '0);
    chk("rst_rlast", axi.rlast, 1'b0);
    chk("rst_bresp", axi.bresp, 2'b00);
    chk("rst_rresp", axi.rresp, 2'b00);
    chk("rst_errcnt", err_cnt, 16'd0);
    rst = 1'b1;
    #1;
    chk("post_awready", axi.awready, 1'b1);
    chk("post_arready", axi.arready, 1'b1);

    wbuf[0] = {SB{8'hA5}}; sbuf[0] = '1;
    wr_burst(4'd1, 32'h40, 8'd0, 3'd6, 2'b01, 0);
    rd_burst(4'd2, 32'h40, 8'd0, 3'd6, 2'b01, 0);

    for (int k = 0; k < 16; k++) begin
      wbuf[k] = DW'(k); sbuf[k] = '1;
    end
    wr_burst(4'd3, 32'h0, 8'd15, 3'd6, 2'b01, 15);
    rd_burst(4'd4, 32'h0, 8'd15, 3'd6, 2'b01, 40);

    for (int n = 0; n < 4; n++) begin
      a = 32'($urandom_range(900, 20)) * 32'(SB);
      l = 8'($urandom_range(7));
      bt = ($urandom_range(1) == 1) ? 2'b01 : 2'b00;
      for (int k = 0; k <= int'(l); k++) begin
        wbuf[k] = rnd_word(); sbuf[k] = '1;
      end
      wr_burst(4'(n), a, l, 3'd6, 2'b01, int'(l));
      for (int k = 0; k <= int'(l); k++) begin
        wbuf[k] = rnd_word(); tmp = rnd_word(); sbuf[k] = tmp[SB-1:0];
      end
      wr_burst(4'(n + 1), a, l, 3'd6, bt, int'(l));
      rd_burst(4'(n + 2), a, l, 3'd6, 2'b01, 30);
    end

    a = 32'(1010 * SB);
    wbuf[0] = '1; sbuf[0] = '1;
    wr_burst(4'd9, a, 8'd0, 3'd6, 2'b01, 0);
    wbuf[0] = rnd_word(); sbuf[0] = SB'(64'hFF);
    wr_burst(4'd9, a, 8'd0, 3'd6, 2'b01, 0);
    tmp = {{(SB - 8){8'hFF}}, wbuf[0][63:0]};
    chk("strb_model", ref_mem[1010], tmp);
    rd_burst(4'd10, a, 8'd0, 3'd6, 2'b01, 0);

    wbuf[0] = rnd_word(); sbuf[0] = '1;
    wr_burst(4'd11, 32'(DEPTH * SB), 8'd0, 3'd6, 2'b01, 0);
    rd_burst(4'd11, 32'h0, 8'd0, 3'd6, 2'b01, 0);
    rd_burst(4'd12, 32'h80, 8'd0, 3'd7, 2'b01, 0);
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = rnd_word(); sbuf[k] = '1;
    end
    wr_burst(4'd13, 32'(1020 * SB), 8'd3, 3'd6, 2'b01, 2);
    #1;
    chk("errcnt_model", err_cnt, 16'(exp_err));
    chk("errcnt_3", err_cnt, 16'd3);

    a = 32'(950 * SB);
    wbuf[0] = rnd_word(); sbuf[0] = '1;
    wr_burst(4'd1, a, 8'd0, 3'd6, 2'b01, 0);
    wbuf[0] = rnd_word();
    fork
      wr_burst(4'd5, a, 8'd0, 3'd6, 2'b01, 0);
      rd_burst(4'd6, a, 8'd1, 3'd6, 2'b00, 0);
    join
    rd_burst(4'd7, a, 8'd0, 3'd6, 2'b01, 0);

    @(negedge clk);
    #1;
    chk("ar_idle", axi.arready, 1'b1);
    axi.arid = 4'd7; axi.araddr = 32'h0; axi.arlen = 8'd15;
    axi.arsize = 3'd6; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("b5_rvalid", axi.rvalid, 1'b1);
    chk("b5_rdata", axi.rdata, ref_mem[5]);
    rst = 1'b0;
    axi.rready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rvalid", axi.rvalid, 1'b0);
    chk("mid_arready", axi.arready, 1'b0);
    chk("mid_rdata", axi.rdata, '0);
    chk("mid_errcnt", err_cnt, 16'd0);
    exp_err = 0;
    rst = 1'b1;
    #1;
    chk("rel_arready", axi.arready, 1'b1);
    axi.rready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("no_stale", axi.rvalid, 1'b0);
    end
    axi.rready = 1'b0;
    rd_burst(4'd8, 32'h0, 8'd15, 3'd6, 2'b01, 25);
    #1;
    chk("final_errcnt", err_cnt, 16'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
